// File: rtl/riscv_ctrl_pkg.sv
// Shared control encodings for the RISC-V single-cycle and multi-cycle decoders.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH,
    DECODE,
    EXEC_R,
    R_WB,
    MEM_ADDR,
    MEM_RD,
    LD_WB,
    MEM_WR,
    BRANCH
  } ctrl_state_t;

  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  function automatic logic op_supported(input logic [6:0] op);
    return (op == OP_RTYPE) || (op == OP_LOAD) || (op == OP_STORE) || (op == OP_BEQ);
  endfunction

endpackage

// File: rtl/multicycle_controller.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback
// sequencing over a shared memory port and ALU, with a retired-instruction counter.
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       aluop,
  output logic             reg_write,
  output logic             mem2reg,
  output logic             illegal_op,
  output logic [CNT_W-1:0] retired
);

  ctrl_state_t state, state_nxt;
  logic        retire;

  // State register and retired-instruction counter; reset wins over any transition.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= FETCH;
      retired <= '0;
    end else begin
      state <= state_nxt;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  // Next-state selection and retire strobe for the edge leaving a final phase.
  always_comb begin
    state_nxt = state;
    retire    = 1'b0;
    case (state)
      FETCH:    if (mem_ready) state_nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:          state_nxt = EXEC_R;
          OP_LOAD, OP_STORE: state_nxt = MEM_ADDR;
          OP_BEQ:            state_nxt = BRANCH;
          default:           state_nxt = FETCH;
        endcase
      end
      EXEC_R:   state_nxt = R_WB;
      R_WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEM_ADDR: state_nxt = (opcode == OP_LOAD) ? MEM_RD : MEM_WR;
      MEM_RD:   if (mem_ready) state_nxt = LD_WB;
      LD_WB: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      MEM_WR: begin
        if (mem_ready) begin
          state_nxt = FETCH;
          retire    = 1'b1;
        end
      end
      BRANCH: begin
        state_nxt = FETCH;
        retire    = 1'b1;
      end
      default:  state_nxt = FETCH;
    endcase
  end

  // Datapath control decode; everything is held low while reset is asserted.
  always_comb begin
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_RS2;
    aluop      = ALUOP_ADD;
    reg_write  = 1'b0;
    mem2reg    = 1'b0;
    illegal_op = 1'b0;
    if (!reset) begin
      case (state)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = SRCB_FOUR;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        DECODE: begin
          alu_src_b  = SRCB_IMM;
          illegal_op = !op_supported(opcode);
        end
        EXEC_R: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_FUNCT;
        end
        R_WB:     reg_write = 1'b1;
        MEM_ADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = SRCB_IMM;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        LD_WB: begin
          reg_write = 1'b1;
          mem2reg   = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          aluop     = ALUOP_SUB;
          pc_src    = 1'b1;
          pc_write  = zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: per-cycle control vectors and
// the retire count compared against an instruction-level reference model.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic          mem_read, mem_write, iord, ir_write, pc_write, pc_src;
  logic          alu_src_a, reg_write, mem2reg, illegal_op;
  logic [1:0]    alu_src_b, aluop;
  logic [CW-1:0] retired;

  int passes = 0;
  int total  = 0;
  int fails  = 0;
  int m_ret  = 0;

  multicycle_controller #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .aluop(aluop), .reg_write(reg_write), .mem2reg(mem2reg), .illegal_op(illegal_op),
    .retired(retired)
  );

  always #5 clk = ~clk;

  logic [13:0] obs;
  assign obs = {mem_read, mem_write, iord, ir_write, pc_write, pc_src, alu_src_a,
                alu_src_b, aluop, reg_write, mem2reg, illegal_op};

  function automatic logic [13:0] ctl(input logic mr, input logic mw, input logic io,
                                      input logic irw, input logic pcw, input logic pcs,
                                      input logic asa, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic rw,
                                      input logic m2r, input logic ill);
    return {mr, mw, io, irw, pcw, pcs, asa, asb, aop, rw, m2r, ill};
  endfunction

  // Expected control vectors for each phase of an instruction.
  localparam logic [13:0] V_ZERO = '0;
  logic [13:0] v_fetch_wait, v_fetch, v_dec, v_dec_ill, v_exec, v_rwb, v_addr,
               v_rd, v_ldwb, v_wr, v_br_t, v_br_n;

  initial begin
    v_fetch_wait = ctl(1, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    v_fetch      = ctl(1, 0, 0, 1, 1, 0, 0, 2'b01, 2'b00, 0, 0, 0);
    v_dec        = ctl(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 0);
    v_dec_ill    = ctl(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0, 0, 1);
    v_exec       = ctl(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b10, 0, 0, 0);
    v_rwb        = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 0);
    v_addr       = ctl(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 0, 0, 0);
    v_rd         = ctl(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    v_ldwb       = ctl(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 1, 0);
    v_wr         = ctl(0, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 0);
    v_br_t       = ctl(0, 0, 0, 0, 1, 1, 1, 2'b00, 2'b01, 0, 0, 0);
    v_br_n       = ctl(0, 0, 0, 0, 0, 1, 1, 2'b00, 2'b01, 0, 0, 0);
  end

  task automatic check_vec(input string tag, input logic [13:0] e);
    total++;
    assert (obs === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  task automatic check_ret(input string tag);
    logic [CW-1:0] e;
    e = CW'(m_ret % (1 << CW));
    total++;
    assert (retired === e) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, retired, e);
    end
  endtask

  // One clock cycle: drive inputs, let decode settle, compare, advance past the edge.
  task automatic phase(input string tag, input logic [13:0] e, input logic rdy);
    mem_ready = rdy;
    zero      = 1'($urandom);
    #1;
    check_vec(tag, e);
    @(posedge clk);
    #1;
  endtask

  function automatic logic is_legal(input logic [6:0] op);
    return op == 7'b0110011 || op == 7'b0000011 || op == 7'b0100011 || op == 7'b1100011;
  endfunction

  // Runs one whole instruction, starting in the FETCH cycle.
  task automatic run_instr(input logic [6:0] op, input logic z, input int fw, input int mw);
    opcode = op;
    repeat (fw) phase("fetch_wait", v_fetch_wait, 1'b0);
    phase("fetch", v_fetch, 1'b1);
    if (!is_legal(op)) begin
      phase("decode_illegal", v_dec_ill, 1'($urandom));
      check_ret("retired_after_illegal");
      return;
    end
    phase("decode", v_dec, 1'($urandom));
    case (op)
      7'b0110011: begin
        phase("exec_r", v_exec, 1'($urandom));
        phase("r_wb", v_rwb, 1'($urandom));
      end
      7'b0000011: begin
        phase("mem_addr_ld", v_addr, 1'($urandom));
        repeat (mw) phase("mem_rd_wait", v_rd, 1'b0);
        phase("mem_rd", v_rd, 1'b1);
        phase("ld_wb", v_ldwb, 1'($urandom));
      end
      7'b0100011: begin
        phase("mem_addr_st", v_addr, 1'($urandom));
        repeat (mw) phase("mem_wr_wait", v_wr, 1'b0);
        phase("mem_wr", v_wr, 1'b1);
      end
      default: begin
        mem_ready = 1'($urandom);
        zero      = z;
        #1;
        check_vec(z ? "branch_taken" : "branch_not_taken", z ? v_br_t : v_br_n);
        @(posedge clk);
        #1;
      end
    endcase
    m_ret++;
    check_ret("retired_after_instr");
  endtask

  function automatic logic [6:0] rand_op(input logic allow_illegal);
    logic [6:0] op;
    int k;
    k = allow_illegal ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 3));
    case (k)
      0: op = 7'b0110011;
      1: op = 7'b0000011;
      2: op = 7'b0100011;
      3: op = 7'b1100011;
      default: begin
        op = 7'($urandom);
        while (is_legal(op)) op = 7'($urandom);
      end
    endcase
    return op;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_vec("reset_outputs", V_ZERO);
    check_ret("reset_retired");
    mem_ready = 1'b1;
    #1;
    check_vec("reset_outputs_ready", V_ZERO);
    reset = 1'b0;

    // Directed: R-type, load with two wait cycles, taken and not-taken beq, illegal.
    run_instr(7'b0110011, 1'b0, 0, 0);
    run_instr(7'b0000011, 1'b0, 0, 2);
    run_instr(7'b1100011, 1'b1, 0, 0);
    run_instr(7'b1100011, 1'b0, 0, 0);
    run_instr(7'b1111111, 1'b0, 0, 0);
    run_instr(7'b0100011, 1'b0, 1, 1);

    // Reset arrives in MEM_WR while memory is ready: the store must not retire.
    opcode = 7'b0100011;
    phase("fetch", v_fetch, 1'b1);
    phase("decode", v_dec, 1'b1);
    phase("mem_addr_st", v_addr, 1'b1);
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check_vec("reset_in_mem_wr", V_ZERO);
    @(posedge clk);
    #1;
    check_vec("reset_held", V_ZERO);
    m_ret = 0;
    check_ret("retired_after_reset");
    reset = 1'b0;

    // Sixteen retiring instructions wrap the 4-bit counter back to zero.
    for (int i = 0; i < 16; i++)
      run_instr(rand_op(1'b0), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    check_ret("retired_wrap");

    // Random mix including unsupported opcodes.
    for (int i = 0; i < 40; i++)
      run_instr(rand_op(1'b1), 1'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)));

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
